// File: rtl/gf180mcu_osu_sc_gp9t3v3_inv_pipe_if.sv
// Handshake bundle for the elastic inverter pipeline.
// With INV_MASK_EN defined, MASK is carried alongside A.
interface gf180mcu_osu_sc_gp9t3v3_inv_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
);
  localparam int OCC_W = $clog2(STAGES + 1);

  logic             A_VALID;
  logic             A_READY;
  logic [WIDTH-1:0] A;
  logic             Y_VALID;
  logic             Y_READY;
  logic [WIDTH-1:0] Y;
  logic [OCC_W-1:0] OCC;
`ifdef INV_MASK_EN
  logic [WIDTH-1:0] MASK;

  modport master (
    output A_VALID, A, Y_READY, MASK,
    input  A_READY, Y_VALID, Y, OCC
  );
  modport slave (
    input  A_VALID, A, Y_READY, MASK,
    output A_READY, Y_VALID, Y, OCC
  );
`else
  modport master (
    output A_VALID, A, Y_READY,
    input  A_READY, Y_VALID, Y, OCC
  );
  modport slave (
    input  A_VALID, A, Y_READY,
    output A_READY, Y_VALID, Y, OCC
  );
`endif
endinterface

// File: rtl/gf180mcu_osu_sc_gp9t3v3_inv_pipe.sv
// WIDTH-bit inverter in a STAGES-deep elastic valid/ready pipeline.
// INV_MASK_EN selects A ^ MASK on entry instead of ~A.
module gf180mcu_osu_sc_gp9t3v3_inv_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  localparam int OCC_W = $clog2(STAGES + 1)
) (
  input logic CLK,
  input logic RN,
  gf180mcu_osu_sc_gp9t3v3_inv_pipe_if.slave bus
);

  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d    [STAGES];
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] up_v;
  logic [WIDTH-1:0]  up_d [STAGES];
  logic [WIDTH-1:0]  mask;
  logic [OCC_W-1:0]  occ;
  logic              in_fire;
  logic              out_fire;

`ifdef INV_MASK_EN
  assign mask = bus.MASK;
`else
  assign mask = '1;
`endif

  // A stage is ready if it or any stage below it is empty, or Y drains.
  for (genvar k = 0; k < STAGES; k++) begin : g_rdy
    assign rdy[k] = bus.Y_READY | ~(&v[STAGES-1:k]);
  end

  always_comb begin
    up_v[0] = bus.A_VALID;
    up_d[0] = bus.A ^ mask;
    for (int k = 1; k < STAGES; k++) begin
      up_v[k] = v[k-1];
      up_d[k] = d[k-1];
    end
  end

  assign in_fire  = bus.A_VALID & rdy[0];
  assign out_fire = v[STAGES-1] & bus.Y_READY;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      v   <= '0;
      occ <= '0;
      for (int k = 0; k < STAGES; k++) d[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          v[k] <= up_v[k];
          if (up_v[k]) d[k] <= up_d[k];
        end
      end
      occ <= occ + OCC_W'(in_fire) - OCC_W'(out_fire);
    end
  end

  assign bus.A_READY = rdy[0];
  assign bus.Y_VALID = v[STAGES-1];
  assign bus.Y       = d[STAGES-1];
  assign bus.OCC     = occ;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3_inv_pipe.sv
// Randomised bench for the elastic inverter pipeline.
// Reference model: in-order word queue with per-word age.
module tb_gf180mcu_osu_sc_gp9t3v3_inv_pipe;
  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  logic CLK;
  logic RN;

  gf180mcu_osu_sc_gp9t3v3_inv_pipe_if #(
    .WIDTH(WIDTH), .STAGES(STAGES)
  ) bif ();

  gf180mcu_osu_sc_gp9t3v3_inv_pipe #(
    .WIDTH(WIDTH), .STAGES(STAGES)
  ) dut (
    .CLK(CLK),
    .RN (RN),
    .bus(bif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               age;
  } word_t;

  word_t q[$];
  int errors = 0;
  int checks = 0;
  int n_out  = 0;
`ifdef INV_MASK_EN
  logic [WIDTH-1:0] cur_mask = '1;
`endif

  function automatic logic [WIDTH-1:0] mdl(input logic [WIDTH-1:0] a);
`ifdef INV_MASK_EN
    return a ^ cur_mask;
`else
    return ~a;
`endif
  endfunction

  // Entered and left at a falling edge; one clock per call.
  task automatic step(input logic av, input logic [WIDTH-1:0] a,
                      input logic yr, input string tag);
    logic exp_yv, exp_ar, in_f, out_f;
    bif.A_VALID = av;
    bif.A       = a;
    bif.Y_READY = yr;
`ifdef INV_MASK_EN
    bif.MASK    = cur_mask;
`endif
    #1;
    exp_yv = (q.size() > 0) && (q[0].age >= STAGES - 1);
    exp_ar = (q.size() < STAGES) || yr;
    checks++;
    if (bif.Y_VALID !== exp_yv) begin
      errors++;
      $display("FAIL %s y_valid got=%b exp=%b t=%0t", tag, bif.Y_VALID, exp_yv, $time);
    end
    if (exp_yv) begin
      checks++;
      if (bif.Y !== q[0].data) begin
        errors++;
        $display("FAIL %s y got=%h exp=%h t=%0t", tag, bif.Y, q[0].data, $time);
      end
    end
    checks++;
    if (bif.A_READY !== exp_ar) begin
      errors++;
      $display("FAIL %s a_ready got=%b exp=%b t=%0t", tag, bif.A_READY, exp_ar, $time);
    end
    checks++;
    if (bif.OCC !== q.size()) begin
      errors++;
      $display("FAIL %s occ got=%0d exp=%0d t=%0t", tag, bif.OCC, q.size(), $time);
    end
    in_f  = av && exp_ar;
    out_f = exp_yv && yr;
    @(posedge CLK);
    if (out_f) begin
      void'(q.pop_front());
      n_out++;
    end
    foreach (q[i]) q[i].age++;
    if (in_f) q.push_back('{data: mdl(a), age: 0});
    @(negedge CLK);
  endtask

  task automatic check_idle_reset(input string tag);
    checks++;
    if (bif.Y_VALID !== 1'b0 || bif.Y !== '0 ||
        bif.OCC !== '0 || bif.A_READY !== 1'b1) begin
      errors++;
      $display("FAIL %s got yv=%b y=%h occ=%0d ar=%b exp yv=0 y=00 occ=0 ar=1",
               tag, bif.Y_VALID, bif.Y, bif.OCC, bif.A_READY);
    end
  endtask

  task automatic test_reset();
    RN = 1'b0;
    #1;
    check_idle_reset("reset_init");
    @(negedge CLK);
    RN = 1'b1;
    step(1'b1, 8'h11, 1'b0, "rst_fill");
    step(1'b1, 8'h22, 1'b0, "rst_fill");
    #2;
    RN = 1'b0;
    #1;
    check_idle_reset("reset_mid");
    q.delete();
    @(negedge CLK);
    RN = 1'b1;
    step(1'b0, 8'h00, 1'b1, "rst_after");
  endtask

  task automatic test_stream();
    logic [WIDTH-1:0] vals [3];
    int base;
    vals[0] = 8'h00;
    vals[1] = 8'hA5;
    vals[2] = 8'hFF;
    base = n_out;
    for (int i = 0; i < 3; i++) step(1'b1, vals[i], 1'b1, "stream");
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, "stream_drain");
    checks++;
    if (n_out - base != 3) begin
      errors++;
      $display("FAIL stream_count got=%0d exp=3", n_out - base);
    end
  endtask

  task automatic test_backpressure();
    int base;
    base = n_out;
    step(1'b1, 8'h12, 1'b0, "bp_push");
    step(1'b1, 8'h34, 1'b0, "bp_push");
    step(1'b1, 8'h56, 1'b0, "bp_full");
    step(1'b1, 8'h56, 1'b0, "bp_full");
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, "bp_drain");
    checks++;
    if (n_out - base != 2) begin
      errors++;
      $display("FAIL bp_count got=%0d exp=2", n_out - base);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    step(1'b1, 8'hC3, 1'b0, "b2b_fill");
    step(1'b1, 8'h3C, 1'b0, "b2b_fill");
    base = n_out;
    for (int i = 0; i < 10; i++)
      step(1'b1, 8'(i * 17 + 3), 1'b1, "b2b");
    checks++;
    if (n_out - base != 10) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp=10", n_out - base);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, "b2b_drain");
  endtask

  task automatic test_random();
    logic av, yr;
    for (int i = 0; i < 10000; i++) begin
      av = ($urandom_range(0, 3) != 0);
      yr = ($urandom_range(0, 2) != 0);
`ifdef INV_MASK_EN
      cur_mask = WIDTH'($urandom);
`endif
      step(av, WIDTH'($urandom), yr, "rand");
    end
    for (int i = 0; i < 2 * STAGES; i++) step(1'b0, 8'h00, 1'b1, "rand_drain");
  endtask

`ifdef INV_MASK_EN
  task automatic test_mask();
    cur_mask = 8'h0F;
    step(1'b1, 8'h3C, 1'b0, "mask_push");
    cur_mask = 8'hFF;
    step(1'b0, 8'h00, 1'b0, "mask_flight");
    checks++;
    if (bif.Y !== 8'h33) begin
      errors++;
      $display("FAIL mask_const got=%h exp=33", bif.Y);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, "mask_drain");
  endtask
`endif

  initial begin
    bif.A_VALID = 1'b0;
    bif.A       = '0;
    bif.Y_READY = 1'b0;
`ifdef INV_MASK_EN
    bif.MASK    = '1;
`endif
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
`ifdef INV_MASK_EN
    test_mask();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
